// File: rtl/regfile_read_port.sv
// Register file (r1..r31, r0 hard-wired to zero) with two registered read ports,
// same-cycle write bypass, sticky illegal-write-enable flag and saturating write counter.
module regfile_read_port #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREG-1:0]   WriteEn,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  input  logic              Stall,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WriteEnErr,
  output logic [15:0]       WriteCount
);

  typedef enum logic {ERR_OK = 1'b0, ERR_SET = 1'b1} err_state_e;

  localparam logic [NREG-1:0] WE_ONE = NREG'(1);

  logic              wr_illegal;
  logic              wr_ok;
  logic [DATA_W-1:0] post_wr [NREG];

  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [15:0]       cnt_q, cnt_d;
  err_state_e        err_q, err_d;

  // Multi-hot detected by clearing the lowest set bit and testing what remains.
  always_comb begin
    wr_illegal = WriteEn[0] | (|(WriteEn & (WriteEn - WE_ONE)));
    wr_ok      = (|WriteEn) & ~wr_illegal;
  end

  // post_wr is the register file as it will look after this edge, so reading it
  // gives the same-cycle bypass without a separate compare path.
  for (genvar k = 0; k < NREG; k++) begin : g_reg
    if (k == 0) begin : g_zero
      assign post_wr[k] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] reg_q, reg_d;

      always_comb begin
        reg_d = (wr_ok && WriteEn[k]) ? WriteData : reg_q;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) reg_q <= '0;
        else       reg_q <= reg_d;
      end

      assign post_wr[k] = reg_d;
    end
  end

  always_comb begin
    rd1_d = Stall ? rd1_q : post_wr[ReadRegister1];
    rd2_d = Stall ? rd2_q : post_wr[ReadRegister2];
    cnt_d = (wr_ok && (cnt_q != '1)) ? cnt_q + 16'd1 : cnt_q;
    err_d = wr_illegal ? ERR_SET : err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
      cnt_q <= '0;
      err_q <= ERR_OK;
    end else begin
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ReadData1  = rd1_q;
  assign ReadData2  = rd2_q;
  assign WriteCount = cnt_q;
  assign WriteEnErr = (err_q == ERR_SET);

endmodule

// File: tb/tb_regfile_read_port.sv
// Scoreboard bench for regfile_read_port: driver pushes model predictions,
// monitor pops and compares one entry per clock.
module tb_regfile_read_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] WriteEn;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        Stall;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        WriteEnErr;
  logic [15:0] WriteCount;

  regfile_read_port #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .WriteEn(WriteEn), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2), .Stall(Stall),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteEnErr(WriteEnErr), .WriteCount(WriteCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          seq;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int seq   = 0;

  // Behavioural reference: architectural register contents and visible outputs.
  logic [31:0] mem [32];
  logic [31:0] m_rd1, m_rd2;
  logic        m_err;
  int          m_cnt;

  task automatic chk(input string name, input int sq, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s seq=%0d actual=%h required=%h", name, sq, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    m_rd1 = '0;
    m_rd2 = '0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic cycle(input logic [31:0] we, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2, input logic st);
    exp_t e;
    int   nbits;
    @(negedge clk);
    WriteEn       = we;
    WriteData     = wd;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    Stall         = st;
    nbits = $countones(we);
    if (nbits == 1 && !we[0]) begin
      for (int i = 1; i < 32; i++) if (we[i]) mem[i] = wd;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else if (nbits != 0) begin
      m_err = 1'b1;
    end
    if (!st) begin
      m_rd1 = mem[a1];
      m_rd2 = mem[a2];
    end
    seq++;
    e.seq = seq;
    e.rd1 = m_rd1;
    e.rd2 = m_rd2;
    e.err = m_err;
    e.cnt = 16'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_left", seq, 32'(sb.size()), 32'd0);
  endtask

  task automatic rand_cycles(input int n, input bit allow_bad);
    logic [31:0] we;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) we = '0;
      else if (r == 1 && allow_bad) begin
        if ($urandom_range(0, 1) == 0) we = 32'h1 | $urandom;
        else we = (32'h1 << $urandom_range(1, 15)) | (32'h1 << $urandom_range(16, 31));
      end else we = 32'h1 << $urandom_range(1, 31);
      cycle(we, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 7) == 0));
    end
  endtask

  // Reset asserted between edges with a write pending: outputs clear with no clock,
  // the pending write is lost and r5 reads zero afterwards.
  task automatic reset_check();
    drain();
    @(negedge clk);
    #2;
    WriteEn   = 32'h20;
    WriteData = 32'h77;
    reset     = 1'b1;
    #1;
    chk("rst_async_rd1", seq, ReadData1, 32'd0);
    chk("rst_async_rd2", seq, ReadData2, 32'd0);
    chk("rst_async_err", seq, 32'(WriteEnErr), 32'd0);
    chk("rst_async_cnt", seq, 32'(WriteCount), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_rd1", seq, ReadData1, 32'd0);
    chk("rst_hold_cnt", seq, 32'(WriteCount), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    WriteEn = '0;
    cycle('0, '0, 5'd5, 5'd5, 1'b0);
    drain();
    chk("rst_r5_rd1", seq, ReadData1, 32'd0);
    chk("rst_r5_rd2", seq, ReadData2, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd1", e.seq, ReadData1, e.rd1);
        chk("rd2", e.seq, ReadData2, e.rd2);
        chk("err", e.seq, 32'(WriteEnErr), 32'(e.err));
        chk("cnt", e.seq, 32'(WriteCount), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    reset = 1'b1;
    WriteEn = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    Stall = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_rd1", 0, ReadData1, 32'd0);
    chk("init_err", 0, 32'(WriteEnErr), 32'd0);
    chk("init_cnt", 0, 32'(WriteCount), 32'd0);
    reset = 1'b0;

    cycle(32'h20, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0);
    cycle('0, '0, 5'd5, 5'd5, 1'b0);
    drain();
    chk("basic_rd1", seq, ReadData1, 32'hDEADBEEF);
    chk("basic_rd2", seq, ReadData2, 32'hDEADBEEF);
    chk("basic_cnt", seq, 32'(WriteCount), 32'd1);

    cycle(32'h1 << 3, 32'hA, 5'd0, 5'd0, 1'b0);
    cycle(32'h1 << 9, 32'h12345678, 5'd9, 5'd3, 1'b0);
    drain();
    chk("bypass_rd1", seq, ReadData1, 32'h12345678);
    chk("bypass_rd2", seq, ReadData2, 32'hA);

    cycle(32'h1 << 7, 32'h11, 5'd0, 5'd0, 1'b0);
    cycle('0, '0, 5'd7, 5'd7, 1'b0);
    cycle(32'h1 << 7, 32'h22, 5'd7, 5'd7, 1'b1);
    cycle('0, '0, 5'd7, 5'd7, 1'b1);
    cycle('0, '0, 5'd7, 5'd7, 1'b1);
    drain();
    chk("stall_hold", seq, ReadData1, 32'h11);
    cycle('0, '0, 5'd7, 5'd7, 1'b0);
    drain();
    chk("stall_release", seq, ReadData1, 32'h22);

    rand_cycles(800, 1'b0);
    reset_check();

    cycle(32'h1, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    cycle('0, '0, 5'd0, 5'd0, 1'b0);
    drain();
    chk("r0_rd1", seq, ReadData1, 32'd0);
    chk("r0_err", seq, 32'(WriteEnErr), 32'd1);
    chk("r0_cnt", seq, 32'(WriteCount), 32'd0);

    cycle(32'h30, 32'h55, 5'd4, 5'd5, 1'b0);
    cycle('0, '0, 5'd4, 5'd5, 1'b0);
    drain();
    chk("multi_r4", seq, ReadData1, 32'd0);
    chk("multi_r5", seq, ReadData2, 32'd0);
    cycle(32'h1 << 4, 32'h99, 5'd0, 5'd0, 1'b0);
    cycle('0, '0, 5'd4, 5'd0, 1'b0);
    drain();
    chk("multi_sticky", seq, 32'(WriteEnErr), 32'd1);
    chk("multi_legal_rd", seq, ReadData1, 32'h99);

    rand_cycles(500, 1'b1);
    reset_check();

    for (int i = 0; i < 65540; i++)
      cycle(32'h1 << $urandom_range(1, 31), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
    drain();
    chk("cnt_saturate", seq, 32'(WriteCount), 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
